// File: rtl/hash_table_pkg.sv
// -----------------------------------------------------------------------------
// hash_table package
// Shared types for the hash-table pipeline: command encoding, head RAM word
// and the pdata record passed from head_table_lookup to data_table.
// No ports (package).
// -----------------------------------------------------------------------------
package hash_table;

  localparam int KEY_WIDTH      = 8;
  localparam int VALUE_WIDTH    = 8;
  localparam int HEAD_PTR_WIDTH = 8;
  localparam int BUCKET_WIDTH   = 4;

  // Three bits leave room for opcodes this stage does not know about; those
  // pass through untouched.
  typedef enum logic [2:0] {
    OP_INIT   = 3'd0,
    OP_SEARCH = 3'd1,
    OP_INSERT = 3'd2,
    OP_DELETE = 3'd3
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } head_ram_data_t;

  typedef struct packed {
    ht_command_t               cmd;
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_ptr_val;
  } ht_pdata_t;

  // Opcodes that rewrite a bucket's head pointer downstream.
  function automatic logic is_modifying(ht_opcode_t op);
    return (op == OP_INSERT) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/head_table_wr_if.sv
// -----------------------------------------------------------------------------
// head_table_wr_if
// Head RAM write port, driven by data_table (master) into head_table_lookup
// (slave).
//   wr_addr         bucket to update
//   wr_data_ptr     new head pointer
//   wr_data_ptr_val new head pointer valid flag
//   wr_en           write strobe, one write per cycle
// -----------------------------------------------------------------------------
interface head_table_wr_if;
  import hash_table::*;

  logic [BUCKET_WIDTH-1:0]   wr_addr;
  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr;
  logic                      wr_data_ptr_val;
  logic                      wr_en;

  modport master (output wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
  modport slave  (input  wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
endinterface

// File: rtl/head_lookup_fifo.sv
// -----------------------------------------------------------------------------
// head_lookup_fifo
// Output queue of head lookups. Every resident entry whose bucket matches
// patch_bucket gets its head fields overwritten when patch_en is high.
//   clk, rst_n      clock, async active-low reset (pointers/count only)
//   push, push_data enqueue (caller guarantees not full)
//   pop             dequeue head (caller guarantees not empty)
//   head            entry at the read pointer, '0 when empty
//   count           number of resident entries
//   patch_*         parallel bucket compare / head update
// -----------------------------------------------------------------------------
module head_lookup_fifo
  import hash_table::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  ht_pdata_t               push_data,
  input  logic                    pop,
  output ht_pdata_t               head,
  output logic [CNT_W-1:0]        count,
  input  logic                    patch_en,
  input  logic [BUCKET_WIDTH-1:0] patch_bucket,
  input  head_ram_data_t          patch_data
);

  ht_pdata_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Patching non-resident slots is harmless; the push comes last so a slot
  // being refilled takes the (already forwarded) push data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (patch_en && mem_q[i].bucket == patch_bucket) begin
        mem_q[i].head_ptr     <= patch_data.ptr;
        mem_q[i].head_ptr_val <= patch_data.ptr_val;
      end
    end
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers are log2(DEPTH) wide and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/true_dual_port_ram_single_clock.sv
// -----------------------------------------------------------------------------
// true_dual_port_ram_single_clock
// Generic two-port RAM on one clock. Read latency is 1 cycle, or 2 with
// REGISTER_OUT=1. A read of an address written in the same cycle returns the
// old contents.
//   clk             clock
//   addr_a/b        port addresses
//   data_a/b, we_a/b write data and enables
//   q_a/b           read data
// -----------------------------------------------------------------------------
module true_dual_port_ram_single_clock #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int REGISTER_OUT = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  // NOTE: the array has no reset so it maps onto block RAM; sequential state
  // uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end

  if (REGISTER_OUT != 0) begin : g_reg_out
    logic [DATA_WIDTH-1:0] out_a, out_b;
    always_ff @(posedge clk) begin
      out_a <= rd_a;
      out_b <= rd_b;
    end
    assign q_a = out_a;
    assign q_b = out_b;
  end else begin : g_comb_out
    assign q_a = rd_a;
    assign q_b = rd_b;
  end

endmodule

// File: rtl/head_table_lookup.sv
// -----------------------------------------------------------------------------
// head_table_lookup
// Reads the head pointer of each hashed command's bucket and hands
// {cmd, bucket, head_ptr, head_ptr_val} to data_table. Owns the head RAM
// write port. Build option HT_HEAD_FWD_EN: when defined, head writes are
// forwarded into every lookup in flight or queued; when undefined, modifying
// commands are serialised through the stage instead.
//   clk_i, rst_i               clock, async active-low reset
//   task_i, bucket_i           command and its bucket index
//   task_valid_i/task_ready_o  input handshake (credit based)
//   pdata_out_o                lookup result
//   pdata_out_valid_o/pdata_in_ready_i  output handshake
//   head_table_if              head RAM write port from data_table
//   busy_o                     any lookup in flight or queued
// -----------------------------------------------------------------------------
module head_table_lookup #(
  parameter int BUCKET_WIDTH = hash_table::BUCKET_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int RAM_LATENCY  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  hash_table::ht_command_t task_i,
  input  logic [BUCKET_WIDTH-1:0] bucket_i,
  input  logic                    task_valid_i,
  output logic                    task_ready_o,
  output hash_table::ht_pdata_t   pdata_out_o,
  output logic                    pdata_out_valid_o,
  input  logic                    pdata_in_ready_i,
  head_table_wr_if.slave          head_table_if,
  output logic                    busy_o
);
  import hash_table::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef HT_HEAD_FWD_EN
  typedef struct packed {
    logic                    valid;
    ht_command_t             cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic                    fwd;       // a write hit this entry after its read
    head_ram_data_t          fwd_data;
  } stage_t;
`else
  typedef struct packed {
    logic                    valid;
    ht_command_t             cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
  } stage_t;
`endif

  stage_t                  stage_q [RAM_LATENCY];
  stage_t                  stage_d [RAM_LATENCY];
  stage_t                  last;
  head_ram_data_t          ram_q, wr_data, head_data;
  logic [BUCKET_WIDTH-1:0] wr_addr;
  logic                    wr_en, accept, push, pop, patch_en;
  ht_pdata_t               push_data;
  logic [CNT_W-1:0]        inflight_q, fifo_cnt;
  logic [CNT_W:0]          credit_used;
  head_ram_data_t          unused_q_b;

  assign wr_en   = head_table_if.wr_en;
  assign wr_addr = head_table_if.wr_addr;
  assign wr_data = '{ptr: head_table_if.wr_data_ptr, ptr_val: head_table_if.wr_data_ptr_val};

  assign accept = task_valid_i && task_ready_o;
  assign pop    = pdata_out_valid_o && pdata_in_ready_i;

  // RAM latency is 1 + REGISTER_OUT, so RAM_LATENCY must be 1 or 2.
  true_dual_port_ram_single_clock #(
    .DATA_WIDTH  ($bits(head_ram_data_t)),
    .ADDR_WIDTH  (BUCKET_WIDTH),
    .REGISTER_OUT((RAM_LATENCY > 1) ? 1 : 0)
  ) u_head_ram (
    .clk   (clk_i),
    .addr_a(bucket_i),
    .data_a('0),
    .we_a  (1'b0),
    .q_a   (ram_q),
    .addr_b(wr_addr),
    .data_b(wr_data),
    .we_b  (wr_en),
    .q_b   (unused_q_b)
  );

  // Side pipeline carrying each command alongside its RAM read.
  // NOTE: every field is given a default first so no latch is inferred.
  always_comb begin
    stage_d[0]        = '0;
    stage_d[0].valid  = accept;
    stage_d[0].cmd    = task_i;
    stage_d[0].bucket = bucket_i;
    for (int s = 1; s < RAM_LATENCY; s++) stage_d[s] = stage_q[s-1];
`ifdef HT_HEAD_FWD_EN
    // Stage 0 covers the accept-cycle read, which returns pre-write data.
    for (int s = 0; s < RAM_LATENCY; s++) begin
      if (wr_en && wr_addr == stage_d[s].bucket) begin
        stage_d[s].fwd      = 1'b1;
        stage_d[s].fwd_data = wr_data;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < RAM_LATENCY; s++) stage_q[s] <= '0;
      inflight_q <= '0;
    end else begin
      for (int s = 0; s < RAM_LATENCY; s++) stage_q[s] <= stage_d[s];
      inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(push);
    end
  end

  assign last = stage_q[RAM_LATENCY-1];
  assign push = last.valid;

  // A write in the push cycle itself is not yet in the FIFO, so it must be
  // folded into the pushed word here.
  always_comb begin
    head_data = ram_q;
`ifdef HT_HEAD_FWD_EN
    if (last.fwd) head_data = last.fwd_data;
    if (wr_en && wr_addr == last.bucket) head_data = wr_data;
`endif
    push_data              = '0;
    push_data.cmd          = last.cmd;
    push_data.bucket       = last.bucket;
    push_data.head_ptr     = head_data.ptr;
    push_data.head_ptr_val = head_data.ptr_val;
  end

`ifdef HT_HEAD_FWD_EN
  assign patch_en = wr_en;
`else
  assign patch_en = 1'b0;
`endif

  head_lookup_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .head        (pdata_out_o),
    .count       (fifo_cnt),
    .patch_en    (patch_en),
    .patch_bucket(wr_addr),
    .patch_data  (wr_data)
  );

  assign pdata_out_valid_o = (fifo_cnt != '0);
  assign busy_o            = (inflight_q != '0) || (fifo_cnt != '0);

  // Credits: every in-flight lookup owns a FIFO slot, so pushes never stall.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};

`ifdef HT_HEAD_FWD_EN
  assign task_ready_o = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
`else
  // Without forwarding, a modifying command must drain before the next
  // command reads the head RAM.
  logic last_mod_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      last_mod_q <= 1'b0;
    else if (accept) last_mod_q <= is_modifying(task_i.opcode);
  end

  assign task_ready_o = (credit_used < (CNT_W + 1)'(FIFO_DEPTH)) && !(busy_o && last_mod_q);
`endif

endmodule

// File: tb/tb_head_table_lookup.sv
module tb_head_table_lookup;
  import hash_table::*;

`ifdef HT_HEAD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  ht_command_t task_i;
  logic [3:0]  bucket;
  logic        task_valid, task_ready;
  ht_pdata_t   pdata_out;
  logic        out_valid, in_ready, busy;

  head_table_wr_if wr_bus ();

  head_table_lookup dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .task_i           (task_i),
    .bucket_i         (bucket),
    .task_valid_i     (task_valid),
    .task_ready_o     (task_ready),
    .pdata_out_o      (pdata_out),
    .pdata_out_valid_o(out_valid),
    .pdata_in_ready_i (in_ready),
    .head_table_if    (wr_bus),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_passed = 0;
  logic [7:0] m_ptr [16];
  logic       m_val [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ht_opcode_t op, input logic [7:0] key, input logic [3:0] b);
    task_i     = '{opcode: op, key: key, value: 8'hA5};
    bucket     = b;
    task_valid = 1'b1;
  endtask

  task automatic set_write(input logic [3:0] a, input logic [7:0] p, input logic v);
    wr_bus.wr_addr         = a;
    wr_bus.wr_data_ptr     = p;
    wr_bus.wr_data_ptr_val = v;
    wr_bus.wr_en           = 1'b1;
    m_ptr[a] = p;
    m_val[a] = v;
  endtask

  task automatic head_write(input logic [3:0] a, input logic [7:0] p, input logic v);
    set_write(a, p, v);
    step();
    wr_bus.wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    task_i = '0; bucket = '0; task_valid = 1'b0; in_ready = 1'b0;
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0;
    wr_bus.wr_data_ptr = '0; wr_bus.wr_data_ptr_val = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", task_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_pdata", pdata_out, 0);
    check("rst_busy",  busy, 0);
    rst_i = 1'b1;
    step();

    // Preload head RAM: bucket i -> {0x80|i, 1}, then specific buckets.
    for (int i = 0; i < 16; i++) head_write(4'(i), 8'h80 | 8'(i), 1'b1);
    head_write(4'd5, 8'h12, 1'b1);
    head_write(4'd9, 8'h00, 1'b0);

    // Single SEARCH to bucket 5: output at T+3, busy low at T+4.
    in_ready = 1'b1;
    check("t1_ready", task_ready, 1);
    drive(OP_SEARCH, 8'h55, 4'd5);
    step(); task_valid = 1'b0;
    check("t1_valid_t1", out_valid, 0);
    step();
    check("t1_valid_t2", out_valid, 0);
    step();
    check("t1_valid_t3", out_valid, 1);
    check("t1_ptr",      pdata_out.head_ptr, 8'h12);
    check("t1_val",      pdata_out.head_ptr_val, 1);
    check("t1_bucket",   pdata_out.bucket, 5);
    check("t1_key",      pdata_out.cmd.key, 8'h55);
    check("t1_busy_t3",  busy, 1);
    step();
    check("t1_busy_t4",  busy, 0);
    check("t1_valid_t4", out_valid, 0);

    // Six back-to-back commands with output stalled: four accepted.
    in_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(OP_SEARCH, 8'h10 + 8'(i), 4'(i));
      check($sformatf("t2_ready_%0d", i), task_ready, (i < 4) ? 1 : 0);
      step();
    end
    task_valid = 1'b0;
    check("t2_full_ready", task_ready, 0);
    in_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t2_valid_%0d", j),  out_valid, 1);
      check($sformatf("t2_key_%0d", j),    pdata_out.cmd.key, 8'h10 + 8'(j));
      check($sformatf("t2_bucket_%0d", j), pdata_out.bucket, j);
      check($sformatf("t2_ptr_%0d", j),    pdata_out.head_ptr, m_ptr[j]);
      step();
    end
    check("t2_drained", out_valid, 0);

    // INSERT to bucket 7 held on the output, then a write to bucket 7.
    in_ready = 1'b0;
    check("t3_ready_acc", task_ready, 1);
    drive(OP_INSERT, 8'h77, 4'd7);
    step(); task_valid = 1'b0;
    check("t3_ready_t1", task_ready, FWD ? 1 : 0);
    step(); step();
    check("t3_valid",    out_valid, 1);
    check("t3_ptr_old",  pdata_out.head_ptr, 8'h87);
    set_write(4'd7, 8'h33, 1'b1);
    step(); wr_bus.wr_en = 1'b0;
    check("t3_ptr_held", pdata_out.head_ptr, FWD ? 8'h33 : 8'h87);
    check("t3_val_held", pdata_out.head_ptr_val, 1);
    check("t3_opcode",   pdata_out.cmd.opcode, OP_INSERT);
    in_ready = 1'b1;
    step(); in_ready = 1'b0;
    check("t3_popped", out_valid, 0);
    check("t3_idle",   busy, 0);

    // Write to bucket 9 in the same cycle as a SEARCH accept to bucket 9.
    in_ready = 1'b1;
    set_write(4'd9, 8'h40, 1'b1);
    drive(OP_SEARCH, 8'h99, 4'd9);
    check("t4_ready", task_ready, 1);
    step(); wr_bus.wr_en = 1'b0; task_valid = 1'b0;
    step(); step();
    check("t4_valid", out_valid, 1);
    check("t4_ptr",   pdata_out.head_ptr, FWD ? 8'h40 : 8'h00);
    check("t4_val",   pdata_out.head_ptr_val, FWD ? 1 : 0);
    step();

    // Three queued entries (buckets 3,3,4), then write {3, 0x00, 0}.
    in_ready = 1'b0;
    drive(OP_SEARCH, 8'h31, 4'd3); step();
    drive(OP_SEARCH, 8'h32, 4'd3); step();
    drive(OP_SEARCH, 8'h41, 4'd4); step();
    task_valid = 1'b0;
    step(); step();
    check("t5_queued_valid", out_valid, 1);
    set_write(4'd3, 8'h00, 1'b0);
    step(); wr_bus.wr_en = 1'b0;
    in_ready = 1'b1;
    check("t5_e0_key", pdata_out.cmd.key, 8'h31);
    check("t5_e0_val", pdata_out.head_ptr_val, FWD ? 0 : 1);
    check("t5_e0_ptr", pdata_out.head_ptr, FWD ? 8'h00 : 8'h83);
    step();
    check("t5_e1_key", pdata_out.cmd.key, 8'h32);
    check("t5_e1_val", pdata_out.head_ptr_val, FWD ? 0 : 1);
    step();
    check("t5_e2_bucket", pdata_out.bucket, 4);
    check("t5_e2_ptr",    pdata_out.head_ptr, 8'h84);
    check("t5_e2_val",    pdata_out.head_ptr_val, 1);
    step();
    check("t5_drained", out_valid, 0);

    // Async reset with three lookups resident.
    in_ready = 1'b0;
    drive(OP_SEARCH, 8'h01, 4'd1); step();
    drive(OP_SEARCH, 8'h02, 4'd2); step();
    drive(OP_SEARCH, 8'h06, 4'd6); step();
    task_valid = 1'b0;
    step();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_busy",  busy, 1);
    rst_i = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy",  busy, 0);
    check("t6_rst_pdata", pdata_out, 0);
    step();
    rst_i = 1'b1;
    check("t6_rel_ready", task_ready, 1);
    in_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t6_no_stale_%0d", k), out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/head_table_lookup.md
# head_table_lookup

Stage directly upstream of `data_table`. It accepts hashed commands (command plus bucket index), reads the bucket's head pointer from the head RAM, and delivers `ht_pdata_t` to `data_table` over a valid/ready handshake. It owns the head RAM write port driven by `data_table` through `head_table_if`. It also forwards those writes into lookups that are still in flight or queued, so `data_table` never receives a stale head pointer.

## Interface
- `BUCKET_WIDTH`, default `hash_table::BUCKET_WIDTH`: head RAM address width; the RAM has 2^BUCKET_WIDTH entries.
- `FIFO_DEPTH`, default 4: output queue depth. Must be a power of two, ≥ RAM_LATENCY+1.
- `RAM_LATENCY`, default 2: head RAM read latency (registered output).
- `clk_i` · in · 1 · single clock.
- `rst_i` · in · 1 · reset, asynchronous, active-low.
- `task_i` · in · `ht_command_t` · opcode/key/value.
- `bucket_i` · in · BUCKET_WIDTH · bucket index for `task_i`.
- `task_valid_i` · in · 1 · input valid.
- `task_ready_o` · out · 1 · input ready.
- `pdata_out_o` · out · `ht_pdata_t` · carries cmd, bucket, head_ptr, head_ptr_val.
- `pdata_out_valid_o` · out · 1 · output valid.
- `pdata_in_ready_i` · in · 1 · driven from `data_table`'s `pdata_in_ready_o`.
- `head_table_if` · slave · — · `wr_addr`, `wr_data_ptr`, `wr_data_ptr_val`, `wr_en` from `data_table`.
- `busy_o` · out · 1 · high while any lookup is in flight or queued.

## Operation
- A command is accepted when `task_valid_i && task_ready_o`. On the accept cycle the RAM read address is `bucket_i`.
- A pipeline of RAM_LATENCY stages carries {cmd, bucket, valid} alongside the RAM read. At the last stage the entry is pushed into the output FIFO with the RAM data, or with forwarded data if a forward applies.
- Credit rule: `task_ready_o = (inflight_cnt + fifo_cnt) < FIFO_DEPTH`.
  - `inflight_cnt` counts valid pipeline stages. Both counters are `$clog2(FIFO_DEPTH+1)` bits wide.
  - Because of this rule a push never finds the FIFO full, so there is no pipeline stall.
- Output handshake:
  - `pdata_out_valid_o` is high whenever the FIFO is not empty. The FIFO head is popped on `pdata_out_valid_o && pdata_in_ready_i`.
  - Push and pop in the same cycle leave `fifo_cnt` unchanged.
  - `pdata_out_o` is held stable while valid and not ready, except when forwarding patches it (see below).
- Head writes: `wr_en` writes {wr_data_ptr, wr_data_ptr_val} to head RAM address `wr_addr` in the same cycle.
- Forwarding. Any pipeline stage or FIFO entry whose bucket equals `wr_addr` replaces its head_ptr/head_ptr_val with the write data, in the same cycle as the write. This covers:
  - the accept-cycle read (read-during-write on the RAM returns old data);
  - the entry currently presented on `pdata_out_o`;
  - multiple matching entries, which are all patched.
- Entries already popped are not affected.
- OP_INIT and unknown opcodes pass through unchanged, with whatever head data was read. `data_table` ignores the head fields for these opcodes.
- Wrap-around: FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Reset:
  - Asynchronous assert clears all valid bits, both counters and the FIFO pointers.
  - In-flight and queued commands are dropped.
  - Head RAM contents are not reset; `data_table`'s OP_INIT sequence clears them.

## Timing
- Reset values:
  - `task_ready_o` = 1 (counters are 0).
  - `pdata_out_valid_o` = 0.
  - `pdata_out_o` = '0.
  - `busy_o` = 0.
- Latency: a command accepted in cycle T appears on `pdata_out_o` at T+RAM_LATENCY+1 at the earliest (T+3 by default), provided the FIFO is empty.
- Throughput: one accept per cycle sustained while `pdata_in_ready_i` is continuously high.
- A write at cycle W is visible in every lookup that is resident (pipeline or FIFO) at W, and in every lookup accepted at W or later.

## Configuration
- `HT_HEAD_FWD_EN` defined: forwarding logic is present, as described above.
- `HT_HEAD_FWD_EN` undefined:
  - Comparators and patch muxes are removed, and entries carry raw RAM data.
  - `task_ready_o` is additionally forced low while `busy_o` is high and the last accepted opcode was OP_INSERT or OP_DELETE. This serialises modifying commands; throughput is lower but results are still correct.

## Structure
- Add to package `hash_table`:
  - `head_ram_data_t` {ptr [HEAD_PTR_WIDTH], ptr_val}.
  - `BUCKET_WIDTH`.
  - `ht_pdata_t` gains `bucket`, `head_ptr` and `head_ptr_val` fields if they are not already present.
- Sub-module `head_lookup_fifo`: a patchable FIFO with push, pop, count and a parallel bucket-compare/update port.
- The head RAM is `true_dual_port_ram_single_clock` with REGISTER_OUT=1:
  - port A is read-only;
  - port B is write-only, driven from `head_table_if`.

## Test plan
- Reset then single SEARCH to bucket 5, with head RAM[5] = {ptr 0x12, val 1}, and `pdata_in_ready_i`=1:
  - output at T+3 with head_ptr 0x12, val 1.
  - `busy_o` drops at T+4.
- Hold `pdata_in_ready_i`=0 and drive 6 back-to-back commands:
  - exactly 4 are accepted and `task_ready_o` falls after the 4th;
  - releasing ready drains them in order, with no loss or duplication.
- INSERT to bucket 7 queued on the output, then head write {7, 0x33, 1} while the output is stalled:
  - the held `pdata_out_o` changes to head_ptr 0x33, val 1.
- Head write {9, 0x40, 1} in the same cycle as a SEARCH accept to bucket 9, with old RAM value {0x00, 0}:
  - output head_ptr 0x40, val 1.
- Three queued entries to buckets 3, 3, 4, then write {3, 0x00, 0}:
  - both bucket-3 entries show val 0;
  - the bucket-4 entry is unchanged.
- Async reset asserted mid-stream with 3 entries resident:
  - `pdata_out_valid_o`=0 immediately and `task_ready_o`=1 after release;
  - no stale entries are emitted.
